// File: rtl/wb_sram8_bridge_if.sv
// Bus bundle for wb_sram8_bridge: Wishbone classic slave side plus SRAM control pins.
// The bidirectional SRAM data byte stays a plain port on the bridge.
interface wb_sram8_bridge_if;
  logic [31:0] i_wb_adr;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic        o_wb_err;
  logic [3:0]  o_sram_cs;
  logic        o_sram_read;
  logic        o_sram_write;
  logic [20:0] o_sram_addr;

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err, o_sram_cs, o_sram_read, o_sram_write, o_sram_addr
  );

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err, o_sram_cs, o_sram_read, o_sram_write, o_sram_addr
  );
endinterface

// File: rtl/wb_sram8_bridge.sv
// Wishbone classic 32-bit slave that splits each access into byte-serial
// SETUP/STROBE/HOLD cycles on a 4-chip 2Mx8 asynchronous SRAM bank.
module wb_sram8_bridge #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  wb_sram8_bridge_if.slave bus,
  inout  wire  [7:0]       io_sram_data
);

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

  state_t        state, state_n;
  logic [20:0]   adr_q, adr_n;     // byte address bits [22:2]
  logic          we_q, we_n;
  logic [31:0]   dat_q, dat_n;
  logic [3:0]    rem, rem_n;       // lanes still to be processed
  logic [1:0]    lane, lane_n;
  logic [CW-1:0] cnt, cnt_n, wait_m1;
  logic [3:0]    mask;
  logic          last_strobe, busy_n;
  logic          data_oe;
  logic [7:0]    data_out;

  logic unused_adr;
  assign unused_adr = ^{bus.i_wb_adr[31:23], bus.i_wb_adr[1:0]};

  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    state_n     = state;
    adr_n       = adr_q;
    we_n        = we_q;
    dat_n       = dat_q;
    rem_n       = rem;
    lane_n      = lane;
    cnt_n       = cnt;
    mask        = 4'h0;
    last_strobe = 1'b0;
    wait_m1     = we_q ? CW'(WR_WAIT - 1) : CW'(RD_WAIT - 1);
    case (state)
      IDLE: if (bus.i_wb_cyc && bus.i_wb_stb && !bus.o_wb_ack) begin
        adr_n   = bus.i_wb_adr[22:2];
        we_n    = bus.i_wb_we;
        dat_n   = bus.i_wb_dat;
        // reads always fetch the whole word; writes touch only enabled lanes
        mask    = bus.i_wb_we ? bus.i_wb_sel : 4'hF;
        rem_n   = mask;
        lane_n  = first_lane(mask);
        state_n = (mask == 4'h0) ? ACK : SETUP;
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n   = '0;
      end
      STROBE: if (cnt == wait_m1) begin
        state_n     = HOLD;
        last_strobe = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
      end
      HOLD: begin
        rem_n   = rem & ~(4'b0001 << lane);
        lane_n  = first_lane(rem_n);
        state_n = (rem_n == 4'h0) ? ACK : SETUP;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);
  end

  // Every pin is registered from next-state values so strobes never glitch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      adr_q            <= '0;
      we_q             <= 1'b0;
      dat_q            <= '0;
      rem              <= '0;
      lane             <= '0;
      cnt              <= '0;
      data_oe          <= 1'b0;
      data_out         <= '0;
      bus.o_sram_cs    <= '0;
      bus.o_sram_read  <= 1'b0;
      bus.o_sram_write <= 1'b0;
      bus.o_sram_addr  <= '0;
      bus.o_wb_ack     <= 1'b0;
      bus.o_wb_dat     <= '0;
    end else begin
      state            <= state_n;
      adr_q            <= adr_n;
      we_q             <= we_n;
      dat_q            <= dat_n;
      rem              <= rem_n;
      lane             <= lane_n;
      cnt              <= cnt_n;
      data_oe          <= busy_n && we_n;
      data_out         <= dat_n[{lane_n, 3'b000} +: 8];
      bus.o_sram_cs    <= busy_n ? (4'b0001 << adr_n[20:19]) : 4'h0;
      bus.o_sram_read  <= (state_n == STROBE) && !we_n;
      bus.o_sram_write <= (state_n == STROBE) && we_n;
      if (busy_n)
        bus.o_sram_addr <= {adr_n[18:0], lane_n};
      // an abandoned Wishbone cycle still finishes on the SRAM but is not acked
      bus.o_wb_ack     <= (state_n == ACK) && bus.i_wb_cyc;
      if (last_strobe && !we_q)
        bus.o_wb_dat[{lane, 3'b000} +: 8] <= io_sram_data;
    end
  end

  assign io_sram_data = data_oe ? data_out : 8'hzz;
  assign bus.o_wb_err = 1'b0;

endmodule

// File: tb/tb_wb_sram8_bridge.sv
// Scoreboard bench for wb_sram8_bridge: directed Wishbone accesses against a
// small byte-wide SRAM model; a negedge monitor checks acks and SRAM strobes.
module tb_wb_sram8_bridge;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  wire [7:0] sram_bus;

  wb_sram8_bridge_if bus();

  wb_sram8_bridge #(.RD_WAIT(2), .WR_WAIT(2)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .bus          (bus),
    .io_sram_data (sram_bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0]  cs;
    logic [20:0] addr;
    logic [7:0]  data;
    logic [7:0]  len;
  } ev_t;

  typedef struct {
    int          e0;
    int          lat;
    logic [31:0] dat;
    logic        rd;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;
  ev_t  wr_ev[$], rd_ev[$];
  ev_t  cur_wr, cur_rd;
  int   checks = 0, passes = 0;
  int   cyc_cnt = 0, acks = 0, cs_cycles = 0, excl_viol = 0;
  int   wr_len = 0, rd_len = 0;
  bit   mem_init = 1'b0;
  logic [7:0] mem [0:1023];
  logic [7:0] rd_byte;
  logic [7:0] full_bytes [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [9:0] midx(input logic [3:0] cs, input logic [20:0] a);
    logic [1:0] c;
    c = cs[3] ? 2'd3 : cs[2] ? 2'd2 : cs[1] ? 2'd1 : 2'd0;
    return {c, a[7:0]};
  endfunction

  function automatic ev_t mk_ev(input logic [3:0] cs, input logic [20:0] a,
                                input logic [7:0] d, input logic [7:0] len);
    ev_t x;
    x.cs = cs; x.addr = a; x.data = d; x.len = len;
    return x;
  endfunction

  // SRAM model: drives the bus only while the output-enable strobe is high
  always_comb rd_byte = mem[midx(bus.o_sram_cs, bus.o_sram_addr)];
  assign sram_bus = bus.o_sram_read ? rd_byte : 8'hzz;

  always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge i_clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem_init = 1'b1;
    end
    if (bus.o_sram_cs != 4'h0) cs_cycles++;
    if (bus.o_sram_read && bus.o_sram_write) excl_viol++;
    if (bus.o_sram_write) begin
      wr_len++;
      cur_wr = mk_ev(bus.o_sram_cs, bus.o_sram_addr, sram_bus, 8'(wr_len));
      mem[midx(bus.o_sram_cs, bus.o_sram_addr)] = sram_bus;
    end else if (wr_len != 0) begin
      wr_ev.push_back(cur_wr);
      wr_len = 0;
    end
    if (bus.o_sram_read) begin
      rd_len++;
      cur_rd = mk_ev(bus.o_sram_cs, bus.o_sram_addr, sram_bus, 8'(rd_len));
    end else if (rd_len != 0) begin
      rd_ev.push_back(cur_rd);
      rd_len = 0;
    end
    if (bus.o_wb_ack) begin
      acks++;
      if (sb.size() == 0) begin
        chk("unexpected_ack_queue", 64'(sb.size()), 64'd1);
      end else begin
        e_cur = sb.pop_front();
        chk({e_cur.name, "_lat"}, 64'(cyc_cnt - e_cur.e0 + 1), 64'(e_cur.lat));
        if (e_cur.rd) chk({e_cur.name, "_dat"}, 64'(bus.o_wb_dat), 64'(e_cur.dat));
      end
    end
  end

  task automatic xfer(input string name, input logic [31:0] adr, input logic [3:0] sel,
                      input logic we, input logic [31:0] dat, input int lat,
                      input logic [31:0] edat);
    int   a0;
    bit   got;
    exp_t e;
    @(negedge i_clk);
    bus.i_wb_adr = adr; bus.i_wb_sel = sel; bus.i_wb_we = we; bus.i_wb_dat = dat;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    @(posedge i_clk); #1;
    e.e0 = cyc_cnt; e.lat = lat; e.dat = edat; e.rd = !we; e.name = name;
    sb.push_back(e);
    a0  = acks;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge i_clk);
      if (acks != a0) begin got = 1'b1; break; end
    end
    // request stays up through the edge that ends ACK: must not be re-accepted
    #1;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    if (!got) begin
      chk({name, "_ack_timeout"}, 64'(acks - a0), 64'd1);
      sb.delete();
    end
  endtask

  initial begin
    int n, c0, a0;
    bit found;
    full_bytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    bus.i_wb_adr = '0; bus.i_wb_sel = '0; bus.i_wb_we = 1'b0; bus.i_wb_dat = '0;
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ack",   64'(bus.o_wb_ack),     64'd0);
    chk("rst_err",   64'(bus.o_wb_err),     64'd0);
    chk("rst_cs",    64'(bus.o_sram_cs),    64'd0);
    chk("rst_read",  64'(bus.o_sram_read),  64'd0);
    chk("rst_write", 64'(bus.o_sram_write), 64'd0);
    chk("rst_addr",  64'(bus.o_sram_addr),  64'd0);
    chk("rst_dat",   64'(bus.o_wb_dat),     64'd0);
    i_rst = 1'b0;
    @(posedge i_clk);

    // full-word write
    n = wr_ev.size();
    xfer("wr_full", 32'h0000_0004, 4'hF, 1'b1, 32'hA1B2C3D4, 17, 32'h0);
    chk("wr_full_nev", 64'(wr_ev.size() - n), 64'd4);
    for (int i = 0; i < 4; i++)
      if (wr_ev.size() > n + i)
        chk($sformatf("wr_full_ev%0d", i), 64'(wr_ev[n+i]),
            64'(mk_ev(4'b0001, 21'(4 + i), full_bytes[i], 8'd2)));

    // read back, sel deliberately 0: all lanes must still be fetched
    n = rd_ev.size(); c0 = wr_ev.size();
    xfer("rd_back", 32'h0000_0004, 4'h0, 1'b0, 32'h0, 17, 32'hA1B2C3D4);
    chk("rd_back_nev", 64'(rd_ev.size() - n), 64'd4);
    chk("rd_back_nowr", 64'(wr_ev.size() - c0), 64'd0);
    for (int i = 0; i < 4; i++)
      if (rd_ev.size() > n + i)
        chk($sformatf("rd_back_ev%0d", i), 64'(rd_ev[n+i]),
            64'(mk_ev(4'b0001, 21'(4 + i), full_bytes[i], 8'd2)));

    // partial write on chip 3
    n = wr_ev.size();
    xfer("wr_part", 32'h0060_0010, 4'b0100, 1'b1, 32'h00EE0000, 5, 32'h0);
    chk("wr_part_nev", 64'(wr_ev.size() - n), 64'd1);
    if (wr_ev.size() > n)
      chk("wr_part_ev", 64'(wr_ev[n]), 64'(mk_ev(4'b1000, 21'h12, 8'hEE, 8'd2)));

    // empty write
    n = wr_ev.size(); c0 = cs_cycles;
    xfer("wr_empty", 32'h0000_0008, 4'h0, 1'b1, 32'hFFFFFFFF, 1, 32'h0);
    chk("wr_empty_nev", 64'(wr_ev.size() - n), 64'd0);
    chk("wr_empty_cs",  64'(cs_cycles - c0),   64'd0);

    // reset during lane 2 STROBE of a write
    @(negedge i_clk);
    bus.i_wb_adr = 32'h0000_0020; bus.i_wb_sel = 4'hF; bus.i_wb_we = 1'b1;
    bus.i_wb_dat = 32'h55667788; bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (bus.o_sram_write && bus.o_sram_addr[1:0] == 2'd2) begin found = 1'b1; break; end
    end
    chk("rst_mid_reach_lane2", 64'(found), 64'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_mid_cs",    64'(bus.o_sram_cs),    64'd0);
    chk("rst_mid_write", 64'(bus.o_sram_write), 64'd0);
    chk("rst_mid_read",  64'(bus.o_sram_read),  64'd0);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0; bus.i_wb_we = 1'b0;
    a0 = acks;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (20) @(posedge i_clk);
    chk("rst_mid_noack", 64'(acks - a0), 64'd0);
    xfer("rd_after_rst", 32'h0000_0004, 4'hF, 1'b0, 32'h0, 17, 32'hA1B2C3D4);

    // drop cyc during lane 1 of a read
    n = rd_ev.size(); a0 = acks;
    @(negedge i_clk);
    bus.i_wb_adr = 32'h0000_0004; bus.i_wb_sel = 4'hF; bus.i_wb_we = 1'b0;
    bus.i_wb_cyc = 1'b1; bus.i_wb_stb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (bus.o_sram_read && bus.o_sram_addr[1:0] == 2'd1) begin found = 1'b1; break; end
    end
    chk("drop_reach_lane1", 64'(found), 64'd1);
    bus.i_wb_cyc = 1'b0; bus.i_wb_stb = 1'b0;
    repeat (25) @(posedge i_clk);
    chk("drop_noack", 64'(acks - a0), 64'd0);
    chk("drop_nev", 64'(rd_ev.size() - n), 64'd4);
    for (int i = 0; i < 4; i++)
      if (rd_ev.size() > n + i)
        chk($sformatf("drop_ev%0d", i), 64'({rd_ev[n+i].addr, rd_ev[n+i].len}),
            64'({21'(4 + i), 8'd2}));
    xfer("rd_after_drop", 32'h0060_0010, 4'hF, 1'b0, 32'h0, 17, 32'h00EE0000);

    chk("strobe_excl", 64'(excl_viol), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/wb_sram8_bridge.md
# wb_sram8_bridge

Wishbone-classic slave that turns 32-bit Amber bus accesses into byte-serial cycles on the board's external asynchronous 2Mx8 SRAM bank (four chips, 8 MB total). It sits inside the system module, between the Wishbone interconnect and the top-level SRAM pins. Its strobe and chip-select outputs are active-high; the top level inverts them to the pin-level `_n` signals.

## Interface
- `RD_WAIT`, 2: cycles the read strobe is held per byte (≥1).
- `WR_WAIT`, 2: cycles the write strobe is held per byte (≥1).
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_wb_adr`  in  32  byte address. Bits [22:21] select the chip, [20:2] select the word, [1:0] are ignored. Bits [31:23] are ignored; decoding happens upstream.
- `i_wb_sel`  in  4  byte-lane enables.
- `i_wb_we`  in  1  write enable.
- `i_wb_dat`  in  32  write data.
- `i_wb_cyc`, `i_wb_stb`  in  1 each  cycle and strobe.
- `o_wb_dat`  out  32  read data.
- `o_wb_ack`  out  1  single-cycle acknowledge.
- `o_wb_err`  out  1  tied to 0.
- `o_sram_cs`  out  4  one-hot chip select, active-high.
- `o_sram_read`  out  1  output-enable strobe, active-high.
- `o_sram_write`  out  1  write strobe, active-high.
- `o_sram_addr`  out  21  SRAM byte address.
- `io_sram_data`  inout  8  SRAM data bus.

## Operation
- **States:** IDLE, SETUP, STROBE, HOLD, ACK.
- **Accept:** in IDLE, when `i_wb_cyc & i_wb_stb & !o_wb_ack` is sampled, the block latches address, we, sel and data.
- **Lane selection:**
  - Writes process only lanes whose `sel` bit is set.
  - Reads process all four lanes regardless of `sel`.
  - Lanes are processed in ascending order, 0 to 3.
  - If no lanes are selected, the FSM goes directly to ACK.
- **Per lane:**
  - SETUP: 1 cycle.
  - STROBE: `RD_WAIT` or `WR_WAIT` cycles, with `o_sram_read` or `o_sram_write` high.
  - HOLD: 1 cycle.
  - From HOLD, the FSM moves to SETUP of the next selected lane, or to ACK after the last one.
- **Address:** `o_sram_addr = {adr[20:2], lane[1:0]}`. This is little-endian: lane n maps to `dat[8n+7:8n]`. `o_sram_cs = 1 << adr[22:21]`.
- **Chip select timing:** `o_sram_cs` is asserted from the first SETUP to the last HOLD, continuously across lanes. It is 0 in IDLE and ACK.
- **Data bus:**
  - `io_sram_data` is driven with the lane byte in SETUP, STROBE and HOLD of write lanes only.
  - It is high-Z otherwise, including during every read cycle.
- **Read capture:** the byte is captured into `o_wb_dat[8n+7:8n]` on the clock edge that ends the last STROBE cycle of lane n.
- **ACK:**
  - `o_wb_ack` is 1 for exactly one cycle, then the FSM returns to IDLE.
  - `o_wb_dat` holds its value until the next read capture.
- **Cycle abort:** if `i_wb_cyc` drops mid-transaction, the byte sequence still completes (no glitches on SRAM strobes). `o_wb_ack` is suppressed if `i_wb_cyc` is low in ACK.
- **Strobe exclusivity:** `o_sram_read` and `o_sram_write` are never high simultaneously.
- **Strobe boundaries:** neither strobe is high in SETUP or HOLD, so address and data are stable around every strobe edge.

## Timing
- **Reset values:**
  - `o_wb_ack`, `o_sram_cs`, `o_sram_read`, `o_sram_write`, `o_wb_err`: 0.
  - `o_sram_addr`: 0. `o_wb_dat`: 0.
  - `io_sram_data`: high-Z. FSM: IDLE.
- **Reset mid-transaction:** all SRAM controls drop asynchronously, the transaction is abandoned, and no ack is issued.
- **Outputs:** all are registered.
- **Cycle numbering:** counted from the accepting edge E0. Cycle 1 is the first cycle after E0.
- **Read latency:** ack is high in cycle 4·(RD_WAIT+2)+1. With the default RD_WAIT=2, that is cycle 17.
- **Write latency:** with k lanes selected, ack is high in cycle k·(WR_WAIT+2)+1.
  - k=0: cycle 1.
  - Full word with default WR_WAIT: cycle 17.
- **Back-to-back:** a request held through the ack cycle is not re-accepted. The earliest new accept is the edge ending the IDLE cycle after ACK.

## Test plan
- **Full-word write:** after reset, write `adr=0x0000_0004`, `sel=F`, `dat=0xA1B2C3D4`.
  - Four SETUP/STROBE/HOLD groups on chip 0.
  - Addresses 4, 5, 6, 7 with data D4, C3, B2, A1.
  - 2-cycle `o_sram_write` per byte; ack in cycle 17.
- **Read back:** read `0x0000_0004` from an SRAM model preloaded as above.
  - `o_wb_dat=0xA1B2C3D4` at ack, cycle 17.
  - `io_sram_data` is never driven by the DUT.
- **Chip select and partial write:** write `adr=0x0060_0010`, `sel=4'b0100`, `dat=0x00EE0000`.
  - `o_sram_cs=4'b1000`.
  - Exactly one byte EE is written at SRAM address `0x000012`.
  - Ack in cycle 5.
- **Empty write:** write with `sel=0`; ack in cycle 1, and no SRAM strobe or cs activity.
- **Reset mid-operation:** assert `i_rst` during the STROBE of lane 2 of a write.
  - cs, read and write go to 0 immediately; the data bus goes high-Z.
  - No ack. After release, the FSM is in IDLE and a new read completes normally.
- **Cycle dropped:** drop `i_wb_cyc` during lane 1 of a read.
  - The SRAM sequence finishes through lane 3 with no truncated strobe.
  - `o_wb_ack` stays 0; the next request is accepted normally.
